// File: rtl/irq_encoder16_pkg.sv
// Shared constants, FSM state encoding and helpers for the 16-line IRQ encoder.
package irq_encoder16_pkg;

    localparam int unsigned NREQ   = 16;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-to-4 priority encoder; the highest set index wins, any_set flags a hit.
module prio_enc16
    import irq_encoder16_pkg::*;
(
    input  logic [NREQ-1:0]   vec,
    output logic [CODE_W-1:0] idx,
    output logic              any_set
);

    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        // Ascending scan so later (higher) indices overwrite lower ones.
        for (int i = 0; i < NREQ; i++) begin
            if (vec[i]) begin
                idx     = CODE_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder16.sv
// Latching 16-line interrupt encoder with valid/ack handshake and saturating overrun counter.
// Define IRQ_ENCODER16_MASK_EN to add a per-line eligibility mask input.
module irq_encoder16
    import irq_encoder16_pkg::*;
#(
    parameter int unsigned OVF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              ack,
`ifdef IRQ_ENCODER16_MASK_EN
    input  logic [NREQ-1:0]   mask,
`endif
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [NREQ-1:0]   pending,
    output logic [OVF_W-1:0]  ovf_cnt
);

    state_e              state;
    logic [NREQ-1:0]     clr;
    logic [NREQ-1:0]     eligible;
    logic [CODE_W-1:0]   enc_idx;
    logic                enc_any;
    logic                overrun;

`ifdef IRQ_ENCODER16_MASK_EN
    assign eligible = pending & mask;
`else
    assign eligible = pending;
`endif

    assign clr     = (valid && ack) ? onehot(code) : '0;
    // A bit being cleared this cycle can be re-set by req without counting as overrun.
    assign overrun = |(req & pending & ~clr);

    prio_enc16 u_prio_enc16 (
        .vec     (eligible),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            pending <= (pending & ~clr) | req;
            if (overrun && (ovf_cnt != {OVF_W{1'b1}})) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
            end
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        code  <= enc_idx;
                        valid <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_encoder16.sv
// Directed self-checking bench for irq_encoder16 (OVF_W=2 so saturation is reachable).
module tb_irq_encoder16;
    import irq_encoder16_pkg::*;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic              ack;
`ifdef IRQ_ENCODER16_MASK_EN
    logic [NREQ-1:0]   mask;
`endif
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [NREQ-1:0]   pending;
    logic [1:0]        ovf_cnt;

    int vectors;
    int miscompares;

    irq_encoder16 #(.OVF_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
`ifdef IRQ_ENCODER16_MASK_EN
        .mask    (mask),
`endif
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 16'hFFFF; ack = 1'b1;
        tick();
        rst = 1'b0; req = 16'h0000; ack = 1'b0;
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_pending: got %h want 0000", pending); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (code !== 4'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", code); end
        vectors++; if (ovf_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
        tick();
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_req_discard: got %h want 0000", pending); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_valid: got %b want 0", valid); end
    endtask

    task automatic test_single();
        req = 16'h0010;
        tick();
        req = 16'h0000;
        vectors++; if (pending !== 16'h0010) begin miscompares++; $display("FAIL single_pend_t1: got %h want 0010", pending); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_t1: got %b want 0", valid); end
        tick();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_t2: got %b want 1", valid); end
        vectors++; if (code !== 4'd4) begin miscompares++; $display("FAIL single_code_t2: got %0d want 4", code); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_ack: got %b want 0", valid); end
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL single_pend_ack: got %h want 0000", pending); end
        vectors++; if (code !== 4'd4) begin miscompares++; $display("FAIL single_code_hold: got %0d want 4", code); end
    endtask

    task automatic test_priority();
        req = 16'h8001;
        tick();
        req = 16'h0000;
        tick();
        vectors++; if (code !== 4'd15 || valid !== 1'b1) begin miscompares++; $display("FAIL prio_first: got code %0d valid %b want 15/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h0001 || valid !== 1'b0) begin miscompares++; $display("FAIL prio_after_ack1: got pend %h valid %b want 0001/0", pending, valid); end
        tick();
        vectors++; if (code !== 4'd0 || valid !== 1'b1) begin miscompares++; $display("FAIL prio_second: got code %0d valid %b want 0/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h0000 || valid !== 1'b0) begin miscompares++; $display("FAIL prio_after_ack2: got pend %h valid %b want 0000/0", pending, valid); end
    endtask

    task automatic test_no_preempt();
        req = 16'h0008;
        tick();
        req = 16'h0000;
        tick();
        vectors++; if (code !== 4'd3 || valid !== 1'b1) begin miscompares++; $display("FAIL nopre_grant: got code %0d valid %b want 3/1", code, valid); end
        req = 16'h4000;
        tick();
        req = 16'h0000;
        vectors++; if (code !== 4'd3 || pending !== 16'h4008) begin miscompares++; $display("FAIL nopre_hold1: got code %0d pend %h want 3/4008", code, pending); end
        tick();
        vectors++; if (code !== 4'd3 || valid !== 1'b1) begin miscompares++; $display("FAIL nopre_hold2: got code %0d valid %b want 3/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h4000 || valid !== 1'b0) begin miscompares++; $display("FAIL nopre_ack: got pend %h valid %b want 4000/0", pending, valid); end
        tick();
        vectors++; if (code !== 4'd14 || valid !== 1'b1) begin miscompares++; $display("FAIL nopre_next: got code %0d valid %b want 14/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_set_wins();
        req = 16'h0020;
        tick();
        req = 16'h0000;
        tick();
        vectors++; if (code !== 4'd5 || valid !== 1'b1) begin miscompares++; $display("FAIL setwin_grant: got code %0d valid %b want 5/1", code, valid); end
        ack = 1'b1; req = 16'h0020;
        tick();
        ack = 1'b0; req = 16'h0000;
        vectors++; if (pending !== 16'h0020) begin miscompares++; $display("FAIL setwin_pend: got %h want 0020", pending); end
        vectors++; if (ovf_cnt !== 2'd0) begin miscompares++; $display("FAIL setwin_ovf: got %0d want 0", ovf_cnt); end
        tick();
        vectors++; if (code !== 4'd5 || valid !== 1'b1) begin miscompares++; $display("FAIL setwin_repres: got code %0d valid %b want 5/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL setwin_clear: got %h want 0000", pending); end
    endtask

    task automatic test_ack_ignored();
        req = 16'h0002;
        tick();
        req = 16'h0000; ack = 1'b1;
        tick();
        vectors++; if (pending !== 16'h0002 || valid !== 1'b1 || code !== 4'd1) begin
            miscompares++; $display("FAIL ackign: got pend %h valid %b code %0d want 0002/1/1", pending, valid, code);
        end
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h0000 || valid !== 1'b0) begin miscompares++; $display("FAIL ackign_clear: got pend %h valid %b want 0000/0", pending, valid); end
    endtask

`ifdef IRQ_ENCODER16_MASK_EN
    task automatic test_mask();
        mask = 16'h00FF; req = 16'h0180;
        tick();
        req = 16'h0000;
        tick();
        vectors++; if (code !== 4'd7 || pending !== 16'h0180) begin miscompares++; $display("FAIL mask_grant: got code %0d pend %h want 7/0180", code, pending); end
        mask = 16'hFFFF; ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (pending !== 16'h0100 || valid !== 1'b0) begin miscompares++; $display("FAIL mask_ack: got pend %h valid %b want 0100/0", pending, valid); end
        tick();
        vectors++; if (code !== 4'd8 || valid !== 1'b1) begin miscompares++; $display("FAIL mask_unmask: got code %0d valid %b want 8/1", code, valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask
`endif

    task automatic test_ovf_sat();
        logic [1:0] exp_ovf [1:5];
        exp_ovf[1] = 2'd0; exp_ovf[2] = 2'd1; exp_ovf[3] = 2'd2;
        exp_ovf[4] = 2'd3; exp_ovf[5] = 2'd3;
        req = 16'h0004;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (ovf_cnt !== exp_ovf[k]) begin miscompares++; $display("FAIL ovf_cycle%0d: got %0d want %0d", k, ovf_cnt, exp_ovf[k]); end
        end
        req = 16'h0000;
        tick();
        vectors++; if (ovf_cnt !== 2'd3 || code !== 4'd2) begin miscompares++; $display("FAIL ovf_hold: got ovf %0d code %0d want 3/2", ovf_cnt, code); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset_hold();
        req = 16'h0006;
        tick();
        req = 16'h0000;
        tick();
        vectors++; if (valid !== 1'b1 || code !== 4'd2 || pending !== 16'h0006) begin
            miscompares++; $display("FAIL rsthold_pre: got valid %b code %0d pend %h want 1/2/0006", valid, code, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (valid !== 1'b0 || pending !== 16'h0000 || code !== 4'd0 || ovf_cnt !== 2'd0) begin
            miscompares++; $display("FAIL rsthold_post: got valid %b pend %h code %0d ovf %0d want 0/0000/0/0", valid, pending, code, ovf_cnt);
        end
        tick();
        vectors++; if (valid !== 1'b0 || pending !== 16'h0000) begin miscompares++; $display("FAIL rsthold_idle: got valid %b pend %h want 0/0000", valid, pending); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req = '0; ack = 1'b0;
`ifdef IRQ_ENCODER16_MASK_EN
        mask = 16'hFFFF;
`endif
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_set_wins();
        test_ack_ignored();
`ifdef IRQ_ENCODER16_MASK_EN
        test_mask();
`endif
        test_ovf_sat();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_encoder16.md
IRQ_ENCODER16 -- requirements
Module: irq_encoder16

Interface
REQ-001 The block SHALL have one parameter: OVF_W, default 8, width of the saturating overrun counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 16 bits: request pulses; bit i requests service for line i.
REQ-005 The block SHALL have port ack, input, 1 bit: the consumer accepts the presented code.
REQ-006 The block SHALL have port code, output, 4 bits: binary index of the granted line.
REQ-007 The block SHALL have port valid, output, 1 bit: code is valid and held stable.
REQ-008 The block SHALL have port pending, output, 16 bits: the latched request register.
REQ-009 The block SHALL have port ovf_cnt, output, OVF_W bits: the saturating overrun count.

Function
REQ-010 pending SHALL update every cycle as pending <= (pending & ~clr) | req, where clr is the one-hot of code when valid && ack, else 0.
REQ-011 When set and clear of the same bit coincide, set SHALL win and the bit SHALL stay pending.
REQ-012 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-013 In IDLE with any eligible pending bit, the FSM SHALL register code = highest eligible index (bit 15 highest priority), set valid, and enter HOLD.
REQ-014 In HOLD, code and valid SHALL remain stable until ack; on ack the FSM SHALL deassert valid the next cycle and return to IDLE.
REQ-015 ack SHALL be ignored when valid is 0.
REQ-016 A higher-priority request arriving during HOLD SHALL NOT preempt the presented code.
REQ-017 Latency from a req pulse to valid SHALL be 2 cycles from an idle block (cycle t req, t+1 pending, t+2 valid).
REQ-018 Maximum grant rate SHALL be one grant per 2 cycles.
REQ-019 Overrun SHALL be any cycle in which req[i] && pending[i] && !clr[i] for some i; ovf_cnt SHALL increment by 1 per such cycle, regardless of how many bits overrun.
REQ-020 ovf_cnt SHALL saturate at 2^OVF_W-1 and SHALL NOT wrap.
REQ-021 With no eligible pending bit, the FSM SHALL stay in IDLE with valid=0 and code holding its last value.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, pending=0, code=0, valid=0, ovf_cnt=0.
REQ-023 rst SHALL take priority over all inputs; reset during HOLD SHALL drop the presented grant without clearing through ack.
REQ-024 req sampled in the reset cycle SHALL be discarded.

Configuration
REQ-025 Macro IRQ_ENCODER16_MASK_EN defined: a 16-bit input port mask SHALL exist, and a pending bit is eligible only if mask[i]=1.
REQ-026 With IRQ_ENCODER16_MASK_EN defined, masked bits SHALL still latch in pending and SHALL count toward overrun.
REQ-027 With IRQ_ENCODER16_MASK_EN undefined, the mask port SHALL be absent and all pending bits SHALL be eligible.

Structure
REQ-028 Package irq_encoder16_pkg SHALL hold NREQ=16, CODE_W=4, and the state encoding (IDLE, HOLD).
REQ-029 Sub-module prio_enc16 (combinational 16-to-4 priority encoder plus an any-set flag) SHALL perform the encode, instantiated once.

Verification
REQ-030 Reset, then req=16'h0010 for 1 cycle -> pending=16'h0010 at t+1; valid=1, code=4 at t+2; ack -> pending=0 and valid=0 the next cycle.
REQ-031 req=16'h8001 in one cycle -> code=15 first; after ack, code=0; after second ack, pending=0.
REQ-032 In HOLD with code=3, req=16'h4000 -> code stays 3 until ack, then code=14.
REQ-033 In HOLD with code=5, ack together with req bit 5 -> pending[5] stays 1 and code=5 is re-presented; ovf_cnt unchanged. Then, with OVF_W=2 and bit 2 pending, hold req[2] for 5 cycles -> ovf_cnt=3, saturated.
REQ-034 With MASK_EN, mask=16'h00FF and req=16'h0180 -> code=7; bit 8 stays pending; then set mask=16'hFFFF and ack -> code=8.
REQ-035 rst asserted mid-HOLD with pending=16'h0006 -> next cycle valid=0, pending=0, code=0, ovf_cnt=0.
